// File: rtl/answer_judge_if.sv
// answer_judge_if
//   Bundles the controller/entry-stage side of the answer judge.
//   master : game controller + entry stage (drives STATE, DEC, QUESTION,
//            COUNTn_IN, RES_ACK; observes the result signals)
//   slave  : answer_judge itself
interface answer_judge_if;
   logic [3:0]  STATE;
   logic        DEC;
   logic [25:0] QUESTION;
   logic [3:0]  COUNT1_IN;
   logic [3:0]  COUNT2_IN;
   logic [3:0]  COUNT3_IN;
   logic        RES_ACK;
   logic [1:0]  RESULT;
   logic        RES_VALID;
   logic        BUSY;
   logic [1:0]  HIT_CNT;
   logic [3:0]  STREAK;

   modport master (
      output STATE, DEC, QUESTION, COUNT1_IN, COUNT2_IN, COUNT3_IN, RES_ACK,
      input  RESULT, RES_VALID, BUSY, HIT_CNT, STREAK
   );

   modport slave (
      input  STATE, DEC, QUESTION, COUNT1_IN, COUNT2_IN, COUNT3_IN, RES_ACK,
      output RESULT, RES_VALID, BUSY, HIT_CNT, STREAK
   );
endinterface

// File: rtl/answer_judge.sv
// answer_judge
//   Compares the three latched player factor codes against the answer codes
//   of the current question (order-independent, multiset semantics) and
//   reports correct / wrong / invalid with a valid/ack handshake. Tracks a
//   saturating streak of correct judgements.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : answer_judge_if.slave (STATE, DEC, QUESTION, COUNTn_IN, RES_ACK in;
//          RESULT, RES_VALID, BUSY, HIT_CNT, STREAK out)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for DEC in ST_INPUT; WIN/LOSE clears the streak
// WAIT     | one cycle for the entry stage to register the final digit
// CAPTURE  | latch player/answer codes, clear used flags, range check
// MATCH0-2 | match player slot i against the lowest unused equal answer
// REPORT   | RES_VALID high until RES_ACK
module answer_judge #(
   parameter logic [3:0] ST_INPUT   = 4'b0100,
   parameter logic [3:0] ST_WIN     = 4'b1010,
   parameter logic [3:0] ST_LOSE    = 4'b1011,
   parameter int         MAX_CODE   = 4,
   parameter int         STREAK_MAX = 15
) (
   input logic          CLK,
   input logic          RST,
   answer_judge_if.slave bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_MATCH0  = 3'd3;
   localparam logic [2:0] S_MATCH1  = 3'd4;
   localparam logic [2:0] S_MATCH2  = 3'd5;
   localparam logic [2:0] S_REPORT  = 3'd6;

   localparam logic [3:0] MAX_C = MAX_CODE[3:0];
   localparam logic [3:0] SMAX  = STREAK_MAX[3:0];

   logic [2:0]       state_q,   state_d;
   logic [2:0][3:0]  p_q,       p_d;
   logic [2:0][3:0]  a_q,       a_d;
   logic [2:0]       used_q,    used_d;
   logic [1:0]       hit_q,     hit_d;
   logic [1:0]       result_q,  result_d;
   logic [1:0]       hit_cnt_q, hit_cnt_d;
   logic [3:0]       streak_q,  streak_d;

   logic [3:0] p_cur;
   logic [1:0] hit_new;
   logic       unused_question;

   assign unused_question = ^bus.QUESTION[25:12];

   always_comb begin
      case (state_q)
         S_MATCH1: p_cur = p_q[1];
         S_MATCH2: p_cur = p_q[2];
         default:  p_cur = p_q[0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      a_d       = a_q;
      used_d    = used_q;
      hit_d     = hit_q;
      result_d  = result_q;
      hit_cnt_d = hit_cnt_q;
      streak_d  = streak_q;
      hit_new   = hit_q;

      case (state_q)
         S_IDLE: begin
            if (bus.DEC && bus.STATE == ST_INPUT) begin
               state_d = S_WAIT;
            end else if (bus.STATE == ST_WIN || bus.STATE == ST_LOSE) begin
               streak_d = '0;
            end
         end
         S_WAIT: state_d = S_CAPTURE;
         S_CAPTURE: begin
            p_d       = {bus.COUNT3_IN, bus.COUNT2_IN, bus.COUNT1_IN};
            a_d       = {bus.QUESTION[11:8], bus.QUESTION[7:4], bus.QUESTION[3:0]};
            used_d    = '0;
            hit_d     = '0;
            result_d  = 2'b00;
            hit_cnt_d = '0;
            if (bus.COUNT1_IN > MAX_C || bus.COUNT2_IN > MAX_C ||
                bus.COUNT3_IN > MAX_C) begin
               result_d = 2'b11;
               streak_d = '0;
               state_d  = S_REPORT;
            end else begin
               state_d  = S_MATCH0;
            end
         end
         S_MATCH0, S_MATCH1, S_MATCH2: begin
            // Lowest unused equal answer slot wins; consumed slots give
            // multiset semantics for duplicated factors.
            if (!used_q[0] && a_q[0] == p_cur) begin
               used_d[0] = 1'b1;
               hit_new   = hit_q + 2'd1;
            end else if (!used_q[1] && a_q[1] == p_cur) begin
               used_d[1] = 1'b1;
               hit_new   = hit_q + 2'd1;
            end else if (!used_q[2] && a_q[2] == p_cur) begin
               used_d[2] = 1'b1;
               hit_new   = hit_q + 2'd1;
            end
            hit_d = hit_new;
            if (state_q == S_MATCH2) begin
               hit_cnt_d = hit_new;
               state_d   = S_REPORT;
               if (hit_new == 2'd3) begin
                  result_d = 2'b01;
                  if (streak_q != SMAX) streak_d = streak_q + 4'd1;
               end else begin
                  result_d = 2'b10;
                  streak_d = '0;
               end
            end else begin
               state_d = state_q + 3'd1;
            end
         end
         S_REPORT: begin
            if (bus.RES_ACK) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         p_q       <= '0;
         a_q       <= '0;
         used_q    <= '0;
         hit_q     <= '0;
         result_q  <= 2'b00;
         hit_cnt_q <= '0;
         streak_q  <= '0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         a_q       <= a_d;
         used_q    <= used_d;
         hit_q     <= hit_d;
         result_q  <= result_d;
         hit_cnt_q <= hit_cnt_d;
         streak_q  <= streak_d;
      end
   end

   assign bus.RESULT    = result_q;
   assign bus.RES_VALID = (state_q == S_REPORT);
   assign bus.BUSY      = (state_q != S_IDLE);
   assign bus.HIT_CNT   = hit_cnt_q;
   assign bus.STREAK    = streak_q;

endmodule

// File: doc/answer_judge.md
Name: answer_judge

Overview:
- Sits directly downstream of the player-entry stage and receives its latched answer digits COUNT1_OUT..COUNT3_OUT.
- Compares the three entered factor codes against the answer field of the current question set from the question DB, ignoring order.
- Reports correct, wrong or invalid to the game controller through a valid/ack handshake.
- Keeps a streak-of-correct-answers counter.

Parameters:
- ST_INPUT, 4'b0100: controller STATE encoding for INPUT.
- ST_WIN, 4'b1010: STATE encoding for WIN.
- ST_LOSE, 4'b1011: STATE encoding for LOSE.
- MAX_CODE, 4: highest legal factor code (0='-', 1=2, 2=3, 3=5, 4=7).
- STREAK_MAX, 15: saturation value of STREAK.

Ports:
- CLK  in  1  system clock; all flops use the rising edge.
- RST  in  1  asynchronous, active-low reset.
- STATE  in  4  controller state.
- DEC  in  1  decide button pulse; the same pulse the entry stage sees.
- QUESTION  in  26  question set: [25:12] difficulty plus problem; [11:0] answer codes A2,A1,A0, 4 bits each.
- COUNT1_IN  in  4  player code, slot 0 (from COUNT1_OUT).
- COUNT2_IN  in  4  player code, slot 1 (from COUNT2_OUT).
- COUNT3_IN  in  4  player code, slot 2 (from COUNT3_OUT).
- RES_ACK  in  1  controller has consumed RESULT.
- RESULT  out  2  00 none, 01 correct, 10 wrong, 11 invalid entry.
- RES_VALID  out  1  RESULT is valid; held until acknowledged.
- BUSY  out  1  high in every state except IDLE.
- HIT_CNT  out  2  number of matched slots in the last judgement.
- STREAK  out  4  consecutive correct judgements.

Behaviour:
- Reset (RST low, asynchronous): FSM goes to IDLE. RESULT=00, RES_VALID=0, BUSY=0, HIT_CNT=0, STREAK=0. Internal latches and used flags are cleared.
- Reset mid-operation aborts with no report.
- FSM states: IDLE, WAIT, CAPTURE, MATCH0, MATCH1, MATCH2, REPORT.
- IDLE: DEC=1 with STATE==ST_INPUT moves to WAIT. DEC in any other STATE is ignored.
- IDLE, streak clear: STATE==ST_WIN or ST_LOSE clears STREAK (new game).
- WAIT: exactly one cycle. It covers the entry stage's one-cycle register delay on COUNTn_OUT. Go to CAPTURE.
- CAPTURE:
  - Latch P0..P2 from COUNT1_IN..COUNT3_IN and A0..A2 from QUESTION[3:0], [7:4], [11:8].
  - Clear the used flags U0..U2 and the hit counter.
  - If any Pi > MAX_CODE, go to REPORT with RESULT=11 and HIT_CNT=0.
  - Otherwise go to MATCH0.
- MATCHi (i=0,1,2), one cycle each:
  - Find the lowest index j with !Uj and Aj==Pi.
  - If found, set Uj and increment hit.
  - The code 0 ('-') matches only an answer code 0.
  - MATCH2 goes to REPORT with RESULT=01 if hit==3, else 10, and HIT_CNT=hit.
- Latency: DEC at cycle n gives RES_VALID=1 at cycle n+6 (valid entry) or n+3 (invalid entry).
- REPORT:
  - RES_VALID=1; RESULT and HIT_CNT are held stable.
  - On the first cycle in REPORT, STREAK increments on 01 (saturating at STREAK_MAX) and clears on 10 or 11. This happens once per judgement.
  - RES_ACK=1 returns to IDLE next cycle with RES_VALID=0. RESULT and HIT_CNT keep their values until the next CAPTURE.
- DEC while BUSY is dropped (not queued), including DEC in the same cycle as RES_ACK.
- Changes on STATE, QUESTION or COUNTn_IN after CAPTURE do not affect the judgement in progress.
- RES_ACK outside REPORT is ignored.
- Duplicate factors are handled as a multiset: P={1,1,2} against A={1,2,2} gives hit=2, result wrong.

Test Plan:
- Order independence: A=(2,1,3) i.e. QUESTION[11:0]=12'h312, P=(1,2,3), DEC in ST_INPUT -> RES_VALID at DEC+6, RESULT=01, HIT_CNT=3, STREAK 0->1.
- Multiset duplicates: A=(1,2,2), P=(1,1,2) -> RESULT=10, HIT_CNT=2, STREAK cleared to 0.
- Invalid code: P=(1,7,2) -> RES_VALID at DEC+3, RESULT=11, HIT_CNT=0.
- Handshake: hold RES_ACK=0 for 10 cycles -> RESULT stable, BUSY=1; pulse DEC plus RES_ACK together -> returns to IDLE, no new judgement starts.
- Gating and streak: DEC with STATE=4'b0011 -> no activity. 16 consecutive correct answers -> STREAK saturates at 15; STATE=ST_LOSE in IDLE -> STREAK=0.
- Async reset: assert RST=0 during MATCH1 -> outputs reset immediately, and after release the next valid DEC judges normally.
